// File: rtl/otter_branch_pkg.sv
// Shared encodings and types for EX-stage branch resolution and the BHT.
package otter_branch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {
    PCS_NONE     = 3'd0,
    PCS_JALR     = 3'd1,
    PCS_BRANCH   = 3'd2,
    PCS_JAL      = 3'd3,
    PCS_FALLTHRU = 3'd4
  } pc_source_t;

  typedef logic [1:0] bht_ctr_t;

  // Weakly not-taken
  localparam bht_ctr_t BHT_RESET = 2'b01;

  // 2-bit saturating counter step
  function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) begin
      nxt = ctr + 2'b01;
    end else if (!taken && ctr != 2'b00) begin
      nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// Table of 2-bit saturating counters: one combinational read port for IF,
// one saturating update port for EX. Reads see the pre-update value.
module branch_history_table #(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned IDXW        = $clog2(BHT_ENTRIES)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [IDXW-1:0] rd_idx,
  output logic            rd_taken,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic            wr_taken
);
  import otter_branch_pkg::*;

  bht_ctr_t bht [BHT_ENTRIES];

  // Prediction is the counter MSB; no write-to-read bypass
  assign rd_taken = bht[rd_idx][1];

  // Counter storage with saturating update
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= BHT_RESET;
      end
    end else if (wr_en) begin
      bht[wr_idx] <= bht_next(bht[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage resolution of branches, JAL and JALR against the fetch prediction,
// with PC redirect, BHT training and saturating performance counters.
module branch_resolve_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_branch_tgt,
  input  logic [XLEN-1:0] ex_jal_tgt,
  input  logic [XLEN-1:0] ex_jalr_tgt,
  output logic [2:0]      pc_source,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] branch_count,
  output logic [XLEN-1:0] mispredict_count
);
  import otter_branch_pkg::*;

  localparam int unsigned IDXW = $clog2(BHT_ENTRIES);

  pc_source_t      pcs;
  logic            fire;
  logic            legal;
  logic            cond;
  logic            br_taken;
  logic            bht_we;
  logic            mispredict;
  logic [XLEN-1:0] branch_count_q;
  logic [XLEN-1:0] mispredict_count_q;

  // PC bits outside the table index do not affect prediction
  logic unused_if_pc;
  assign unused_if_pc = ^{if_pc[XLEN-1:IDXW+2], if_pc[1:0]};

  assign fire = ex_valid && !ex_stall;

  // Condition evaluation, legality and PC source selection
  always_comb begin
    cond     = 1'b0;
    legal    = 1'b1;
    pcs      = PCS_NONE;
    bht_we   = 1'b0;
    unique case (ex_funct3)
      F3_BEQ, F3_BNE:   cond = (ex_rs1 == ex_rs2);
      F3_BLT, F3_BGE:   cond = ($signed(ex_rs1) < $signed(ex_rs2));
      F3_BLTU, F3_BGEU: cond = (ex_rs1 < ex_rs2);
      default:          legal = 1'b0;
    endcase
    // Odd funct3 encodings are the inverted conditions
    br_taken = cond ^ ex_funct3[0];
    if (fire) begin
      case (ex_opcode)
        OP_BRANCH: begin
          if (legal) begin
            bht_we = 1'b1;
            if (br_taken && !ex_pred_taken) begin
              pcs = PCS_BRANCH;
            end else if (!br_taken && ex_pred_taken) begin
              pcs = PCS_FALLTHRU;
            end
          end
        end
        OP_JAL:  pcs = PCS_JAL;
        OP_JALR: pcs = PCS_JALR;
        default: pcs = PCS_NONE;
      endcase
    end
  end

  assign mispredict = (pcs == PCS_BRANCH) || (pcs == PCS_FALLTHRU);
  assign pc_source  = pcs;
  assign redirect   = (pcs != PCS_NONE);

  // Redirect target mux; fall-through wraps modulo 2^XLEN
  always_comb begin
    redirect_pc = '0;
    case (pcs)
      PCS_JALR:     redirect_pc = ex_jalr_tgt;
      PCS_BRANCH:   redirect_pc = ex_branch_tgt;
      PCS_JAL:      redirect_pc = ex_jal_tgt;
      PCS_FALLTHRU: redirect_pc = ex_pc + XLEN'(4);
      default:      redirect_pc = '0;
    endcase
  end

  // Saturating performance counters, stepped only by resolved legal branches
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (bht_we) begin
      if (branch_count_q != '1) begin
        branch_count_q <= branch_count_q + XLEN'(1);
      end
      if (mispredict && mispredict_count_q != '1) begin
        mispredict_count_q <= mispredict_count_q + XLEN'(1);
      end
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

  branch_history_table #(
    .BHT_ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .CLK      (CLK),
    .RST      (RST),
    .rd_idx   (if_pc[IDXW+1:2]),
    .rd_taken (if_pred_taken),
    .wr_en    (bht_we),
    .wr_idx   (ex_pc[IDXW+1:2]),
    .wr_taken (br_taken)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; a narrow second instance exercises
// counter saturation in a few hundred cycles.
module tb_branch_resolve_unit;
  import otter_branch_pkg::*;

  logic        CLK;
  logic        RST;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic        ex_pred_taken;
  logic [31:0] ex_branch_tgt;
  logic [31:0] ex_jal_tgt;
  logic [31:0] ex_jalr_tgt;
  logic [2:0]  pc_source;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  // Narrow instance for saturation
  logic       rst2;
  logic       ex_valid2;
  logic       pred2;
  logic [2:0] pc_source2;
  logic       redirect2;
  logic [7:0] redirect_pc2;
  logic [7:0] branch_count2;
  logic [7:0] mispredict_count2;

  int n_pass;
  int n_total;

  branch_resolve_unit #(
    .XLEN        (32),
    .BHT_ENTRIES (64)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .ex_valid         (ex_valid),
    .ex_stall         (ex_stall),
    .ex_pc            (ex_pc),
    .ex_opcode        (ex_opcode),
    .ex_funct3        (ex_funct3),
    .ex_rs1           (ex_rs1),
    .ex_rs2           (ex_rs2),
    .ex_pred_taken    (ex_pred_taken),
    .ex_branch_tgt    (ex_branch_tgt),
    .ex_jal_tgt       (ex_jal_tgt),
    .ex_jalr_tgt      (ex_jalr_tgt),
    .pc_source        (pc_source),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  branch_resolve_unit #(
    .XLEN        (8),
    .BHT_ENTRIES (4)
  ) dut_sat (
    .CLK              (CLK),
    .RST              (rst2),
    .if_pc            (8'h00),
    .if_pred_taken    (pred2),
    .ex_valid         (ex_valid2),
    .ex_stall         (1'b0),
    .ex_pc            (8'h20),
    .ex_opcode        (OP_BRANCH),
    .ex_funct3        (F3_BEQ),
    .ex_rs1           (8'h05),
    .ex_rs2           (8'h05),
    .ex_pred_taken    (1'b0),
    .ex_branch_tgt    (8'h44),
    .ex_jal_tgt       (8'h00),
    .ex_jalr_tgt      (8'h00),
    .pc_source        (pc_source2),
    .redirect         (redirect2),
    .redirect_pc      (redirect_pc2),
    .branch_count     (branch_count2),
    .mispredict_count (mispredict_count2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ex_valid      = 1'b0;
    ex_stall      = 1'b0;
    ex_pc         = 32'h0;
    ex_opcode     = 7'h0;
    ex_funct3     = 3'h0;
    ex_rs1        = 32'h0;
    ex_rs2        = 32'h0;
    ex_pred_taken = 1'b0;
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic [31:0] pc,
                       input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic pred);
    ex_valid      = v;
    ex_stall      = st;
    ex_pc         = pc;
    ex_opcode     = op;
    ex_funct3     = f3;
    ex_rs1        = a;
    ex_rs2        = b;
    ex_pred_taken = pred;
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
    if_pc = pc;
    #1;
    check(tag, {31'b0, if_pred_taken}, {31'b0, exp});
  endtask

  task automatic counts(input string tag, input logic [31:0] br, input logic [31:0] mp);
    check({tag, "_br"}, branch_count, br);
    check({tag, "_mp"}, mispredict_count, mp);
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    RST           = 1'b1;
    rst2          = 1'b1;
    ex_valid2     = 1'b0;
    if_pc         = 32'h100;
    ex_branch_tgt = 32'h80;
    ex_jal_tgt    = 32'h1234;
    ex_jalr_tgt   = 32'h5678;
    idle();
    #1;
    lookup("rst_pred", 32'h100, 1'b0);
    counts("rst", 32'd0, 32'd0);
    check("rst_pcs", {29'b0, pc_source}, 32'd0);
    tick();
    RST = 1'b0;

    // beq taken, predicted not-taken
    if_pc = 32'h40;
    drive(1, 0, 32'h40, OP_BRANCH, F3_BEQ, 32'd5, 32'd5, 0);
    check("beq_pcs", {29'b0, pc_source}, 32'd2);
    check("beq_redirect", {31'b0, redirect}, 32'd1);
    check("beq_rpc", redirect_pc, 32'h80);
    lookup("beq_pre_pred", 32'h40, 1'b0);
    tick();
    idle();
    counts("beq", 32'd1, 32'd1);
    lookup("beq_post_pred", 32'h40, 1'b1);

    // Signedness with rs1=-1, rs2=1
    drive(1, 0, 32'h204, OP_BRANCH, F3_BLT, 32'hFFFF_FFFF, 32'd1, 0);
    check("blt_pcs", {29'b0, pc_source}, 32'd2);
    tick();
    drive(1, 0, 32'h208, OP_BRANCH, F3_BLTU, 32'hFFFF_FFFF, 32'd1, 1);
    check("bltu_pcs", {29'b0, pc_source}, 32'd4);
    check("bltu_rpc", redirect_pc, 32'h20C);
    tick();
    drive(1, 0, 32'h20C, OP_BRANCH, F3_BGEU, 32'hFFFF_FFFF, 32'd1, 1);
    check("bgeu_redirect", {31'b0, redirect}, 32'd0);
    tick();
    idle();
    counts("sign", 32'd4, 32'd3);
    lookup("bltu_entry", 32'h208, 1'b0);
    lookup("bgeu_entry", 32'h20C, 1'b1);

    // Saturate index 0 at 11, then alias from 0x100
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h0, OP_BRANCH, F3_BEQ, 32'd7, 32'd7, 1);
      tick();
    end
    idle();
    lookup("sat_hi_pred", 32'h0, 1'b1);
    if_pc = 32'h0;
    drive(1, 0, 32'h100, OP_BRANCH, F3_BNE, 32'd7, 32'd7, 1);
    check("alias_pcs", {29'b0, pc_source}, 32'd4);
    check("alias_rpc", redirect_pc, 32'h104);
    lookup("alias_same_cycle", 32'h0, 1'b1);
    tick();
    lookup("alias_entry10", 32'h0, 1'b1);
    tick();
    idle();
    lookup("alias_entry01", 32'h0, 1'b0);
    counts("alias", 32'd10, 32'd5);

    // Saturate index 2 at 00: decrement then increment must land on 01
    drive(1, 0, 32'h208, OP_BRANCH, F3_BLTU, 32'd9, 32'd3, 0);
    check("sat_lo_pcs", {29'b0, pc_source}, 32'd0);
    tick();
    drive(1, 0, 32'h208, OP_BRANCH, F3_BEQ, 32'd3, 32'd3, 0);
    tick();
    idle();
    lookup("sat_lo_entry", 32'h208, 1'b0);
    counts("sat_lo", 32'd12, 32'd6);

    // Stall holds state; resolution on first non-stalled cycle
    drive(1, 1, 32'h300, OP_BRANCH, F3_BEQ, 32'd1, 32'd1, 0);
    check("stall_redirect", {31'b0, redirect}, 32'd0);
    check("stall_pcs", {29'b0, pc_source}, 32'd0);
    tick();
    counts("stall", 32'd12, 32'd6);
    lookup("stall_pred", 32'h300, 1'b0);
    drive(1, 0, 32'h300, OP_BRANCH, F3_BEQ, 32'd1, 32'd1, 0);
    check("unstall_pcs", {29'b0, pc_source}, 32'd2);
    tick();
    idle();
    counts("unstall", 32'd13, 32'd7);
    lookup("unstall_pred", 32'h300, 1'b1);

    // JAL, JALR, illegal funct3, invalid slot
    drive(1, 0, 32'h400, OP_JAL, 3'b000, 32'd0, 32'd0, 0);
    check("jal_pcs", {29'b0, pc_source}, 32'd3);
    check("jal_rpc", redirect_pc, 32'h1234);
    tick();
    drive(1, 0, 32'h404, OP_JALR, 3'b000, 32'd0, 32'd0, 0);
    check("jalr_pcs", {29'b0, pc_source}, 32'd1);
    check("jalr_rpc", redirect_pc, 32'h5678);
    tick();
    drive(1, 0, 32'h300, OP_BRANCH, 3'b010, 32'd2, 32'd2, 0);
    check("f3_010_redirect", {31'b0, redirect}, 32'd0);
    check("f3_010_rpc", redirect_pc, 32'h0);
    tick();
    drive(0, 0, 32'h400, OP_JAL, 3'b000, 32'd0, 32'd0, 0);
    check("invalid_redirect", {31'b0, redirect}, 32'd0);
    idle();
    counts("jump", 32'd13, 32'd7);
    lookup("f3_010_pred", 32'h300, 1'b1);

    // Fall-through wraps past the top of the address space
    drive(1, 0, 32'hFFFF_FFFC, OP_BRANCH, F3_BNE, 32'd4, 32'd4, 1);
    check("wrap_pcs", {29'b0, pc_source}, 32'd4);
    check("wrap_rpc", redirect_pc, 32'h0);
    tick();
    idle();
    counts("wrap", 32'd14, 32'd8);

    // Async reset between edges after 3 taken updates
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h10, OP_BRANCH, F3_BEQ, 32'd8, 32'd8, 1);
      tick();
    end
    lookup("pre_rst_pred", 32'h10, 1'b1);
    #1;
    RST = 1'b1;
    #1;
    lookup("async_rst_pred", 32'h10, 1'b0);
    counts("async_rst", 32'd0, 32'd0);
    tick();
    lookup("rst_edge_pred", 32'h10, 1'b0);
    counts("rst_edge", 32'd0, 32'd0);
    RST = 1'b0;
    idle();

    // Saturation at all-ones on the narrow instance
    rst2      = 1'b0;
    ex_valid2 = 1'b1;
    #1;
    check("sat_pcs", {29'b0, pc_source2}, 32'd2);
    repeat (256) tick();
    check("sat_mp", {24'b0, mispredict_count2}, 32'hFF);
    check("sat_br", {24'b0, branch_count2}, 32'hFF);
    tick();
    check("sat_mp_hold", {24'b0, mispredict_count2}, 32'hFF);
    check("sat_br_hold", {24'b0, branch_count2}, 32'hFF);
    ex_valid2 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
